// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network readout path.
package snn_pkg;

  localparam int DEFAULT_WINDOW = 40;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_N7   = 2'd1,
    CLS_N8   = 2'd2,
    CLS_TIE  = 2'd3
  } class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } dec_state_e;

endpackage

// File: rtl/spike_counter.sv
// Per-input saturating spike counter with clear/enable; optional first-spike
// index latch when SPIKE_FIRST_LATENCY_EN is defined.
module spike_counter #(
  parameter int WINDOW = 40,
  parameter int CNT_W  = 6,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
`ifdef SPIKE_FIRST_LATENCY_EN
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] first_nxt,
`endif
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Next-value is exported so the top can capture the final sample on the same edge
  always_comb begin
    cnt_nxt = cnt;
    if (clr)                                 cnt_nxt = '0;
    else if (en && spike && cnt != CNT_MAX)  cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

`ifdef SPIKE_FIRST_LATENCY_EN
  localparam logic [CNT_W-1:0] NO_SPIKE = CNT_W'(WINDOW);

  logic [CNT_W-1:0] first;

  always_comb begin
    first_nxt = first;
    if (clr)                                   first_nxt = NO_SPIKE;
    else if (en && spike && first == NO_SPIKE) first_nxt = CNT_W'(idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first <= '0;
    else        first <= first_nxt;
  end
`endif

endmodule

// File: rtl/spike_window_decoder.sv
// Windowed n7/n8 spike counter and classifier with valid/ready result.
// Optional SPIKE_FIRST_LATENCY_EN adds first7/first8 and first-spike tie-break.
module spike_window_decoder
  import snn_pkg::*;
#(
  parameter int WINDOW     = DEFAULT_WINDOW,
  parameter int CNT_W      = 6,
  parameter int MIN_SPIKES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             n7,
  input  logic             n8,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
`ifdef SPIKE_FIRST_LATENCY_EN
  output logic [CNT_W-1:0] first7,
  output logic [CNT_W-1:0] first8,
`endif
  output logic [1:0]       class_id,
  output logic [CNT_W-1:0] cnt7,
  output logic [CNT_W-1:0] cnt8
);

  // Index is widened if needed so a narrow count width never truncates the window
  localparam int LOG_W = $clog2(WINDOW + 1);
  localparam int IDX_W = (CNT_W > LOG_W) ? CNT_W : LOG_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  dec_state_e state, nxt;
  logic clr, en, done;
  logic [IDX_W-1:0] win_idx;

  logic [1:0]            spike;
  logic [1:0][CNT_W-1:0] cnt_nxt;
  logic [1:0][CNT_W-1:0] cnt_q;
  class_e                cls, cls_q;

  assign spike = {n8, n7};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    clr  = 1'b0;
    en   = 1'b0;
    done = 1'b0;
    case (state)
      ST_IDLE:  if (start) begin clr = 1'b1; nxt = ST_COUNT; end
      ST_COUNT: begin
        en = 1'b1;
        if (win_idx == LAST_IDX) begin done = 1'b1; nxt = ST_HOLD; end
      end
      ST_HOLD:  if (result_ready) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  win_idx <= '0;
    else if (clr) win_idx <= '0;
    else if (en)  win_idx <= win_idx + 1'b1;
  end

`ifdef SPIKE_FIRST_LATENCY_EN
  logic [1:0][CNT_W-1:0] first_nxt;
  logic [1:0][CNT_W-1:0] first_q;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_lane
    spike_counter #(.WINDOW(WINDOW), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .en        (en),
      .spike     (spike[g]),
`ifdef SPIKE_FIRST_LATENCY_EN
      .idx       (win_idx),
      .first_nxt (first_nxt[g]),
`endif
      .cnt_nxt   (cnt_nxt[g])
    );
  end

  // Classify on the post-sample counts so the last sample is included
  always_comb begin
    logic [CNT_W-1:0] mx;
    mx  = (cnt_nxt[0] > cnt_nxt[1]) ? cnt_nxt[0] : cnt_nxt[1];
    cls = CLS_TIE;
    if (32'(mx) < 32'(MIN_SPIKES))     cls = CLS_NONE;
    else if (cnt_nxt[0] > cnt_nxt[1])  cls = CLS_N7;
    else if (cnt_nxt[1] > cnt_nxt[0])  cls = CLS_N8;
`ifdef SPIKE_FIRST_LATENCY_EN
    else if (first_nxt[0] < first_nxt[1]) cls = CLS_N7;
    else if (first_nxt[1] < first_nxt[0]) cls = CLS_N8;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cls_q <= CLS_NONE;
    end else if (done) begin
      cnt_q <= cnt_nxt;
      cls_q <= cls;
    end
  end

`ifdef SPIKE_FIRST_LATENCY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    first_q <= '0;
    else if (done) first_q <= first_nxt;
  end
  assign first7 = first_q[0];
  assign first8 = first_q[1];
`endif

  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_HOLD);
  assign class_id     = cls_q;
  assign cnt7         = cnt_q[0];
  assign cnt8         = cnt_q[1];

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder: default instance plus a CNT_W=3
// instance sharing the same stimulus to exercise counter saturation.
module tb_spike_window_decoder;

  localparam int WINDOW = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, n7 = 1'b0, n8 = 1'b0, result_ready = 1'b0;

  logic       busy, result_valid;
  logic [1:0] class_id;
  logic [5:0] cnt7, cnt8;
  logic       busy_s, result_valid_s;
  logic [1:0] class_id_s;
  logic [2:0] cnt7_s, cnt8_s;
`ifdef SPIKE_FIRST_LATENCY_EN
  logic [5:0] first7, first8;
  logic [2:0] first7_s, first8_s;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spike_window_decoder #(.WINDOW(WINDOW), .CNT_W(6), .MIN_SPIKES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n7(n7), .n8(n8),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
`ifdef SPIKE_FIRST_LATENCY_EN
    .first7(first7), .first8(first8),
`endif
    .class_id(class_id), .cnt7(cnt7), .cnt8(cnt8)
  );

  spike_window_decoder #(.WINDOW(WINDOW), .CNT_W(3), .MIN_SPIKES(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .n7(n7), .n8(n8),
    .busy(busy_s), .result_valid(result_valid_s), .result_ready(result_ready),
`ifdef SPIKE_FIRST_LATENCY_EN
    .first7(first7_s), .first8(first8_s),
`endif
    .class_id(class_id_s), .cnt7(cnt7_s), .cnt8(cnt8_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 silent, 1 n7 bursts 10-14/25-29, 2 both 1010 in phase,
  // 3 n7 1010 / n8 0101, 4 n8 constant high
  function automatic logic p7(input int mode, input int i);
    case (mode)
      1:       return (i >= 10 && i <= 14) || (i >= 25 && i <= 29);
      2, 3:    return (i % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic p8(input int mode, input int i);
    case (mode)
      2:       return (i % 2) == 0;
      3:       return (i % 2) == 1;
      4:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Start edge, then nsamp sampled edges; checks latency on a full window
  task automatic run_window(input int mode, input int nsamp);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < nsamp; i++) begin
      n7 = p7(mode, i);
      n8 = p8(mode, i);
      if (i == WINDOW - 1) begin
        chk("busy_before_last", busy, 1);
        chk("valid_before_last", result_valid, 0);
      end
      tick();
    end
    n7 = 1'b0;
    n8 = 1'b0;
  endtask

  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("ack_valid_drop", result_valid, 0);
    chk("ack_busy_drop", busy, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_class", class_id, 0);
    chk("rst_cnt7", cnt7, 0);
    chk("rst_cnt8", cnt8, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // n7 bursts, n8 quiet
    run_window(1, WINDOW);
    chk("burst_valid", result_valid, 1);
    chk("burst_busy", busy, 1);
    chk("burst_cnt7", cnt7, 10);
    chk("burst_cnt8", cnt8, 0);
    chk("burst_class", class_id, 1);
    ack();
    chk("idle_keep_cnt7", cnt7, 10);

    // in-phase alternation -> tie
    run_window(2, WINDOW);
    chk("alt_valid", result_valid, 1);
    chk("alt_cnt7", cnt7, 20);
    chk("alt_cnt8", cnt8, 20);
    chk("alt_class", class_id, 3);
`ifdef SPIKE_FIRST_LATENCY_EN
    chk("alt_first7", first7, 0);
    chk("alt_first8", first8, 0);
`endif
    ack();

    // reset in the middle of a window, then a fresh silent window
    run_window(4, 20);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_class", class_id, 0);
    chk("midrst_cnt7", cnt7, 0);
    chk("midrst_cnt8", cnt8, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_result", result_valid, 0);
    run_window(0, WINDOW);
    chk("silent_valid", result_valid, 1);
    chk("silent_cnt7", cnt7, 0);
    chk("silent_cnt8", cnt8, 0);
    chk("silent_class", class_id, 0);
    ack();

    // back-pressure: stay in HOLD with stable outputs
    run_window(1, WINDOW);
    for (int i = 0; i < 15; i++) begin
      n7 = i[0];
      start = ~i[0];
      tick();
      chk("stall_valid", result_valid, 1);
      chk("stall_busy", busy, 1);
      chk("stall_cnt7", cnt7, 10);
      chk("stall_class", class_id, 1);
    end
    n7 = 1'b0;
    start = 1'b1;
    ack();
    start = 1'b0;
    tick();
    chk("hs_start_ignored", busy, 0);
    chk("hs_cnt7_kept", cnt7, 10);

    // n8 constant: saturation on the narrow instance
    run_window(4, WINDOW);
    chk("sat_valid", result_valid_s, 1);
    chk("sat_cnt8", cnt8_s, 7);
    chk("sat_cnt7", cnt7_s, 0);
    chk("sat_class", class_id_s, 2);
    chk("wide_cnt8", cnt8, 40);
    chk("wide_class", class_id, 2);
    ack();

    // shifted alternation: equal counts, n7 spikes first
    run_window(3, WINDOW);
    chk("shift_cnt7", cnt7, 20);
    chk("shift_cnt8", cnt8, 20);
`ifdef SPIKE_FIRST_LATENCY_EN
    chk("shift_first7", first7, 0);
    chk("shift_first8", first8, 1);
    chk("shift_class", class_id, 1);
`else
    chk("shift_class", class_id, 3);
`endif
    ack();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
